riffa_chnl_reg_ctrl: RTL and testbench
======================================

Name: riffa_chnl_reg_ctrl

Overview:
- Channel register front-end directly downstream of the PCIe RX engine's BAR0 decode; consumes {channel, 4-bit offset} register writes and reads using the standard RIFFA offset map (SGRX_LEN=0x0 … FPGA_NAME=0xF).
- Turns host writes into per-channel RX/SG start pulses and serves host reads with a one-deep completion handshake toward the TX completion engine.
- Aggregates per-channel events into the two 32-bit interrupt vectors (clear-on-read) and drives the interrupt request.

Parameters:
C_NUM_CHNL, 4, number of channels, legal 1..12
C_CORESETTINGS, 32'h0, value returned at ADDR_CORESETTINGS
C_FPGA_NAME, 32'h0, value returned at ADDR_FPGA_NAME

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
wr_valid  in  1  register write strobe, one cycle per write
wr_chnl  in  4  target channel
wr_offset  in  4  register offset
wr_data  in  32  write data
rd_valid  in  1  read request valid
rd_ready  out  1  read request accepted
rd_chnl  in  4  read channel
rd_offset  in  4  read offset
rd_tag  in  8  PCIe tag, returned with completion
cpl_valid  out  1  completion valid
cpl_ready  in  1  completion consumed
cpl_data  out  32  read data
cpl_tag  out  8  echoed tag
rx_start  out  C_NUM_CHNL  per-channel RX transaction start pulse
rx_len  out  32*C_NUM_CHNL  per-channel RX length (words)
rx_off  out  31*C_NUM_CHNL  per-channel RX offset
rx_last  out  C_NUM_CHNL  per-channel RX last flag
sgrx_valid  out  C_NUM_CHNL  per-channel SG RX descriptor pulse
sgtx_valid  out  C_NUM_CHNL  per-channel SG TX descriptor pulse
sg_addr  out  64*C_NUM_CHNL  per-channel SG address (last written pair)
sg_len  out  32*C_NUM_CHNL  per-channel SG length
tx_len  in  32*C_NUM_CHNL  channel TX length, readable at ADDR_TX_LEN
tx_off_last  in  32*C_NUM_CHNL  channel TX {offset,last}, ADDR_TX_OFFLAST
rx_xferd  in  32*C_NUM_CHNL  RX words transferred, ADDR_RX_LEN_XFERD
tx_xferd  in  32*C_NUM_CHNL  TX words transferred, ADDR_TX_LEN_XFERD
evt  in  3*C_NUM_CHNL  event pulses; channel c: bit 3c tx_req, 3c+1 tx_done, 3c+2 rx_done
intr_req  out  1  level, high while any vector bit pending

Behaviour:
- Reset (reset_n low, async): all pulses, rd_ready=0 during reset then 1, cpl_valid=0, cpl_data/tag=0, all stored lengths/addresses/offsets=0, vectors=0, intr_req=0.
- Writes (ignored if wr_chnl>=C_NUM_CHNL or offset >=0x8):
  - RX_LEN: store rx_len[c]. RX_OFFLAST: store rx_off[c]=wr_data[31:1], rx_last[c]=wr_data[0]; rx_start[c] one-cycle pulse next cycle with registered values stable same cycle.
  - SGRX_ADDRLO/HI, SGTX_ADDRLO/HI write sg_addr[c][31:0]/[63:32] (shared register). SGRX_LEN/SGTX_LEN store sg_len[c] and pulse sgrx_valid[c]/sgtx_valid[c] next cycle.
- Read FSM states IDLE, CPL:
  - IDLE: rd_ready=1; rd_valid -> capture data/tag, go CPL; cpl_valid asserts next cycle (latency 1).
  - CPL: rd_ready=0; hold cpl_data/cpl_tag stable; cpl_valid&cpl_ready -> IDLE (next request accepted the cycle after).
  - Read map: 0x8 tx_len, 0x9 tx_off_last, 0xA C_CORESETTINGS, 0xB vector0, 0xC vector1, 0xD rx_xferd, 0xE tx_xferd, 0xF C_FPGA_NAME; offsets 0x0..0x7 return 0; channel>=C_NUM_CHNL returns 0 except 0xA, 0xB, 0xC, 0xF (global).
- Interrupt vectors: event index e=3c+k sets vector0[e] if e<32 else vector1[e-32]. Bits sticky until read.
  - Reading vector0/1 returns the current value and clears exactly the returned bits at capture; an event arriving in the capture cycle stays set (set beats clear).
  - intr_req = |{vector1,vector0}, registered (one cycle after set/clear).
- Simultaneous write and read in same cycle are independent; read of a register being written returns the pre-write value.
- Reset mid-read drops the completion; no cpl_valid after reset release until a new request.

Test Plan:
- Write ch1 RX_LEN=0x100 then RX_OFFLAST=0x0000_0011 -> rx_start[1] single pulse, rx_len[1]=0x100, rx_off[1]=0x8, rx_last[1]=1; other channels unchanged.
- Write ch0 SGTX_ADDRLO=0xDEAD_0000, ADDRHI=0x1, SGTX_LEN=0x40 -> sgtx_valid[0] pulse, sg_addr[0]=0x1_DEAD_0000, sg_len[0]=0x40, sgrx_valid quiet.
- Read ch2 0xD tag 0x5A, rx_xferd[2]=0x1234, cpl_ready low 3 cycles -> cpl_valid one cycle after accept, held with data 0x1234 tag 0x5A, rd_ready=0 until handshake.
- C_NUM_CHNL=12, pulse evt[35] and evt[0] -> vector1=0x8, vector0=0x1, intr_req=1; read vector0 -> 0x1 returned, cleared; intr_req stays 1 until vector1 read.
- evt[4] pulses in the same cycle a vector0 read with bit 4 already set is captured -> returns bit 4 set, bit 4 remains set afterward.
- Read ch7 with C_NUM_CHNL=4 offset 0x8 -> 0; offset 0xF -> C_FPGA_NAME; assert reset_n low while in CPL -> cpl_valid drops immediately, rd_ready=1 after release.

Source files
------------

// File: rtl/riffa_chnl_reg_ctrl.sv
// riffa_chnl_reg_ctrl -- RIFFA channel register front-end.
//
// Purpose:
//   Decodes {channel, offset} register writes from the PCIe RX BAR0 path.
//   These writes update the per-channel RX and scatter-gather registers and
//   generate one-cycle start/descriptor pulses.
//   Host reads are served through a one-deep completion handshake toward the
//   TX completion engine.
//   Per-channel events are collected into two clear-on-read interrupt
//   vectors, and intr_req is driven from them.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   wr_valid/chnl/offset/data    register write, one cycle per write
//   rd_valid/ready/chnl/offset/tag  read request handshake
//   cpl_valid/ready/data/tag     read completion handshake
//   rx_start/len/off/last        per-channel RX transaction controls
//   sgrx_valid/sgtx_valid        per-channel SG descriptor pulses
//   sg_addr/sg_len               per-channel SG descriptor fields
//   tx_len/tx_off_last/rx_xferd/tx_xferd  per-channel readable status
//   evt                          per-channel {rx_done, tx_done, tx_req} pulses
//   intr_req                     high while any vector bit is pending
//
// Write offsets: 0 SGRX_LEN, 1 SGRX_ADDRLO, 2 SGRX_ADDRHI, 3 RX_LEN,
//                4 RX_OFFLAST, 5 SGTX_LEN, 6 SGTX_ADDRLO, 7 SGTX_ADDRHI.
// Read offsets:  8 TX_LEN, 9 TX_OFFLAST, A CORESETTINGS, B VECT0, C VECT1,
//                D RX_LEN_XFERD, E TX_LEN_XFERD, F FPGA_NAME.

// Per-channel write-side register file.
module riffa_chnl_regs (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en_i,
  input  logic [2:0]  wr_offset_i,
  input  logic [31:0] wr_data_i,
  output logic        rx_start_o,
  output logic [31:0] rx_len_o,
  output logic [30:0] rx_off_o,
  output logic        rx_last_o,
  output logic        sgrx_valid_o,
  output logic        sgtx_valid_o,
  output logic [63:0] sg_addr_o,
  output logic [31:0] sg_len_o
);
  localparam logic [2:0] OFF_SGRX_LEN    = 3'h0;
  localparam logic [2:0] OFF_SGRX_ADDRLO = 3'h1;
  localparam logic [2:0] OFF_SGRX_ADDRHI = 3'h2;
  localparam logic [2:0] OFF_RX_LEN      = 3'h3;
  localparam logic [2:0] OFF_RX_OFFLAST  = 3'h4;
  localparam logic [2:0] OFF_SGTX_LEN    = 3'h5;
  localparam logic [2:0] OFF_SGTX_ADDRLO = 3'h6;
  localparam logic [2:0] OFF_SGTX_ADDRHI = 3'h7;

  logic        rx_start_q, rx_last_q, sgrx_vld_q, sgtx_vld_q;
  logic [31:0] rx_len_q, sg_len_q;
  logic [30:0] rx_off_q;
  logic [63:0] sg_addr_q;

  // Pulses and the values they qualify are written on the same edge.
  // Consumers therefore see stable data in the cycle the pulse is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_start_q <= 1'b0;
      rx_last_q  <= 1'b0;
      sgrx_vld_q <= 1'b0;
      sgtx_vld_q <= 1'b0;
      rx_len_q   <= '0;
      rx_off_q   <= '0;
      sg_len_q   <= '0;
      sg_addr_q  <= '0;
    end else begin
      rx_start_q <= 1'b0;
      sgrx_vld_q <= 1'b0;
      sgtx_vld_q <= 1'b0;
      if (wr_en_i) begin
        case (wr_offset_i)
          OFF_SGRX_LEN: begin
            sg_len_q   <= wr_data_i;
            sgrx_vld_q <= 1'b1;
          end
          OFF_SGTX_LEN: begin
            sg_len_q   <= wr_data_i;
            sgtx_vld_q <= 1'b1;
          end
          // RX and TX SG descriptors share one address register.
          OFF_SGRX_ADDRLO, OFF_SGTX_ADDRLO: sg_addr_q[31:0]  <= wr_data_i;
          OFF_SGRX_ADDRHI, OFF_SGTX_ADDRHI: sg_addr_q[63:32] <= wr_data_i;
          OFF_RX_LEN: rx_len_q <= wr_data_i;
          OFF_RX_OFFLAST: begin
            rx_off_q   <= wr_data_i[31:1];
            rx_last_q  <= wr_data_i[0];
            rx_start_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign rx_start_o   = rx_start_q;
  assign rx_len_o     = rx_len_q;
  assign rx_off_o     = rx_off_q;
  assign rx_last_o    = rx_last_q;
  assign sgrx_valid_o = sgrx_vld_q;
  assign sgtx_valid_o = sgtx_vld_q;
  assign sg_addr_o    = sg_addr_q;
  assign sg_len_o     = sg_len_q;
endmodule

module riffa_chnl_reg_ctrl #(
  parameter int          C_NUM_CHNL     = 4,
  parameter logic [31:0] C_CORESETTINGS = 32'h0,
  parameter logic [31:0] C_FPGA_NAME    = 32'h0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr_valid,
  input  logic [3:0]                   wr_chnl,
  input  logic [3:0]                   wr_offset,
  input  logic [31:0]                  wr_data,
  input  logic                         rd_valid,
  output logic                         rd_ready,
  input  logic [3:0]                   rd_chnl,
  input  logic [3:0]                   rd_offset,
  input  logic [7:0]                   rd_tag,
  output logic                         cpl_valid,
  input  logic                         cpl_ready,
  output logic [31:0]                  cpl_data,
  output logic [7:0]                   cpl_tag,
  output logic [C_NUM_CHNL-1:0]        rx_start,
  output logic [C_NUM_CHNL-1:0][31:0]  rx_len,
  output logic [C_NUM_CHNL-1:0][30:0]  rx_off,
  output logic [C_NUM_CHNL-1:0]        rx_last,
  output logic [C_NUM_CHNL-1:0]        sgrx_valid,
  output logic [C_NUM_CHNL-1:0]        sgtx_valid,
  output logic [C_NUM_CHNL-1:0][63:0]  sg_addr,
  output logic [C_NUM_CHNL-1:0][31:0]  sg_len,
  input  logic [C_NUM_CHNL-1:0][31:0]  tx_len,
  input  logic [C_NUM_CHNL-1:0][31:0]  tx_off_last,
  input  logic [C_NUM_CHNL-1:0][31:0]  rx_xferd,
  input  logic [C_NUM_CHNL-1:0][31:0]  tx_xferd,
  input  logic [C_NUM_CHNL-1:0][2:0]   evt,
  output logic                         intr_req
);
  localparam logic [3:0] NCH = 4'(C_NUM_CHNL);

  localparam logic [3:0] RD_TX_LEN       = 4'h8;
  localparam logic [3:0] RD_TX_OFFLAST   = 4'h9;
  localparam logic [3:0] RD_CORESETTINGS = 4'hA;
  localparam logic [3:0] RD_VECT0        = 4'hB;
  localparam logic [3:0] RD_VECT1        = 4'hC;
  localparam logic [3:0] RD_RX_XFERD     = 4'hD;
  localparam logic [3:0] RD_TX_XFERD     = 4'hE;
  localparam logic [3:0] RD_FPGA_NAME    = 4'hF;

  typedef enum logic {ST_IDLE, ST_CPL} rd_state_e;

  // ---------------- write path ----------------
  logic wr_hit;
  assign wr_hit = wr_valid && !wr_offset[3] && (wr_chnl < NCH);

  for (genvar c = 0; c < C_NUM_CHNL; c++) begin : g_ch
    riffa_chnl_regs u_regs (
      .clk          (clk),
      .reset_n      (reset_n),
      .wr_en_i      (wr_hit && (wr_chnl == 4'(c))),
      .wr_offset_i  (wr_offset[2:0]),
      .wr_data_i    (wr_data),
      .rx_start_o   (rx_start[c]),
      .rx_len_o     (rx_len[c]),
      .rx_off_o     (rx_off[c]),
      .rx_last_o    (rx_last[c]),
      .sgrx_valid_o (sgrx_valid[c]),
      .sgtx_valid_o (sgtx_valid[c]),
      .sg_addr_o    (sg_addr[c]),
      .sg_len_o     (sg_len[c])
    );
  end

  // ---------------- read path ----------------
  rd_state_e   state_q, state_d;
  logic        live_q;
  logic [31:0] cpl_data_q;
  logic [7:0]  cpl_tag_q;
  logic        rd_accept;
  logic [31:0] rd_data;
  logic [31:0] sel_tx_len, sel_tx_offlast, sel_rx_xferd, sel_tx_xferd;
  logic [63:0] pend_q, pend_d, vec_clr;
  logic        intr_q;

  // live_q keeps rd_ready low while reset is held, even though the FSM is
  // already in IDLE.
  assign rd_ready  = live_q && (state_q == ST_IDLE);
  assign rd_accept = rd_valid && rd_ready;

  // An out-of-range channel matches no iteration, so per-channel reads
  // return zero.
  always_comb begin
    sel_tx_len     = '0;
    sel_tx_offlast = '0;
    sel_rx_xferd   = '0;
    sel_tx_xferd   = '0;
    for (int c = 0; c < C_NUM_CHNL; c++) begin
      if (rd_chnl == 4'(c)) begin
        sel_tx_len     = tx_len[c];
        sel_tx_offlast = tx_off_last[c];
        sel_rx_xferd   = rx_xferd[c];
        sel_tx_xferd   = tx_xferd[c];
      end
    end
    case (rd_offset)
      RD_TX_LEN:       rd_data = sel_tx_len;
      RD_TX_OFFLAST:   rd_data = sel_tx_offlast;
      RD_CORESETTINGS: rd_data = C_CORESETTINGS;
      RD_VECT0:        rd_data = pend_q[31:0];
      RD_VECT1:        rd_data = pend_q[63:32];
      RD_RX_XFERD:     rd_data = sel_rx_xferd;
      RD_TX_XFERD:     rd_data = sel_tx_xferd;
      RD_FPGA_NAME:    rd_data = C_FPGA_NAME;
      default:         rd_data = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (rd_accept) state_d = ST_CPL;
      ST_CPL:  if (cpl_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      live_q     <= 1'b0;
      cpl_data_q <= '0;
      cpl_tag_q  <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (rd_accept) begin
        cpl_data_q <= rd_data;
        cpl_tag_q  <= rd_tag;
      end
    end
  end

  assign cpl_valid = (state_q == ST_CPL);
  assign cpl_data  = cpl_data_q;
  assign cpl_tag   = cpl_tag_q;

  // ---------------- interrupt vectors ----------------
  // {vector1, vector0} are kept as one 64-bit pending register.
  // A read clears only the bits it returned.
  // The OR with new events comes last, so an event in the capture cycle
  // survives the clear.
  always_comb begin
    vec_clr = '0;
    if (rd_accept) begin
      if (rd_offset == RD_VECT0) vec_clr[31:0]  = pend_q[31:0];
      if (rd_offset == RD_VECT1) vec_clr[63:32] = pend_q[63:32];
    end
    pend_d = (pend_q & ~vec_clr) | 64'(evt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
      intr_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      intr_q <= |pend_q;
    end
  end

  assign intr_req = intr_q;
endmodule

// File: tb/tb_riffa_chnl_reg_ctrl.sv
module tb_riffa_chnl_reg_ctrl;
  localparam int N = 12;
  localparam logic [31:0] CORE = 32'hC0DE_0001;
  localparam logic [31:0] NAME = 32'h4650_4741;

  logic clk = 1'b0;
  logic reset_n;
  logic wr_valid; logic [3:0] wr_chnl, wr_offset; logic [31:0] wr_data;
  logic rd_valid, rd_ready; logic [3:0] rd_chnl, rd_offset; logic [7:0] rd_tag;
  logic cpl_valid, cpl_ready; logic [31:0] cpl_data; logic [7:0] cpl_tag;
  logic [N-1:0] rx_start, rx_last, sgrx_valid, sgtx_valid;
  logic [N-1:0][31:0] rx_len, sg_len, tx_len, tx_off_last, rx_xferd, tx_xferd;
  logic [N-1:0][30:0] rx_off;
  logic [N-1:0][63:0] sg_addr;
  logic [N-1:0][2:0] evt;
  logic intr_req;

  int checks = 0;
  int errors = 0;

  riffa_chnl_reg_ctrl #(.C_NUM_CHNL(N), .C_CORESETTINGS(CORE), .C_FPGA_NAME(NAME)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_chnl(wr_chnl), .wr_offset(wr_offset), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_chnl(rd_chnl), .rd_offset(rd_offset),
    .rd_tag(rd_tag), .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_data(cpl_data),
    .cpl_tag(cpl_tag), .rx_start(rx_start), .rx_len(rx_len), .rx_off(rx_off),
    .rx_last(rx_last), .sgrx_valid(sgrx_valid), .sgtx_valid(sgtx_valid),
    .sg_addr(sg_addr), .sg_len(sg_len), .tx_len(tx_len), .tx_off_last(tx_off_last),
    .rx_xferd(rx_xferd), .tx_xferd(tx_xferd), .evt(evt), .intr_req(intr_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  chnl;
    logic [3:0]  off;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t tbl[15];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] ch, input logic [3:0] off, input logic [31:0] d);
    wr_valid = 1'b1; wr_chnl = ch; wr_offset = off; wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  // Present a read and hold it until the edge that accepts it.
  task automatic rd_issue(input logic [3:0] ch, input logic [3:0] off, input logic [7:0] tg);
    int n = 0;
    while (!rd_ready && n < 20) begin tick(); n++; end
    if (!rd_ready) chk("rd_ready_timeout", {63'd0, rd_ready}, 64'd1);
    rd_valid = 1'b1; rd_chnl = ch; rd_offset = off; rd_tag = tg;
    tick();
    rd_valid = 1'b0;
  endtask

  // The completion must be valid in the cycle after accept.
  task automatic rd_finish(output logic [31:0] d, output logic [7:0] t);
    chk("cpl_valid_lat1", {63'd0, cpl_valid}, 64'd1);
    d = cpl_data; t = cpl_tag;
    cpl_ready = 1'b1;
    tick();
    cpl_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0] t;

    reset_n = 1'b0; wr_valid = 1'b0; wr_chnl = '0; wr_offset = '0; wr_data = '0;
    rd_valid = 1'b0; rd_chnl = '0; rd_offset = '0; rd_tag = '0; cpl_ready = 1'b0;
    evt = '0;
    for (int c = 0; c < N; c++) begin
      tx_len[c]      = 32'h1000_0000 | c;
      tx_off_last[c] = 32'h2000_0000 | c;
      rx_xferd[c]    = 32'h3000_0000 | c;
      tx_xferd[c]    = 32'h4000_0000 | c;
    end
    rx_xferd[2] = 32'h0000_1234;

    tbl[0]  = '{4'd3,  4'h8, 32'h1000_0003};
    tbl[1]  = '{4'd11, 4'h9, 32'h2000_000B};
    tbl[2]  = '{4'd0,  4'hA, 32'hC0DE_0001};
    tbl[3]  = '{4'd5,  4'hD, 32'h3000_0005};
    tbl[4]  = '{4'd2,  4'hD, 32'h0000_1234};
    tbl[5]  = '{4'd9,  4'hE, 32'h4000_0009};
    tbl[6]  = '{4'd1,  4'hF, 32'h4650_4741};
    tbl[7]  = '{4'd1,  4'h3, 32'h0000_0000};
    tbl[8]  = '{4'd4,  4'h0, 32'h0000_0000};
    tbl[9]  = '{4'd12, 4'h8, 32'h0000_0000};
    tbl[10] = '{4'd13, 4'hD, 32'h0000_0000};
    tbl[11] = '{4'd15, 4'hE, 32'h0000_0000};
    tbl[12] = '{4'd14, 4'hA, 32'hC0DE_0001};
    tbl[13] = '{4'd12, 4'hF, 32'h4650_4741};
    tbl[14] = '{4'd15, 4'hB, 32'h0000_0000};

    // Reset state.
    #12;
    chk("rst_rd_ready", {63'd0, rd_ready}, 64'd0);
    chk("rst_cpl_valid", {63'd0, cpl_valid}, 64'd0);
    chk("rst_cpl_data", {32'd0, cpl_data}, 64'd0);
    chk("rst_intr", {63'd0, intr_req}, 64'd0);
    chk("rst_rx_start", 64'(rx_start), 64'd0);
    chk("rst_sg_addr0", sg_addr[0], 64'd0);
    #3 reset_n = 1'b1;
    tick();
    chk("rd_ready_after_rst", {63'd0, rd_ready}, 64'd1);

    // Table-driven read map.
    for (int i = 0; i < 15; i++) begin
      rd_issue(tbl[i].chnl, tbl[i].off, 8'(8'h10 + i));
      rd_finish(d, t);
      chk($sformatf("rdmap%0d_data", i), {32'd0, d}, {32'd0, tbl[i].exp});
      chk($sformatf("rdmap%0d_tag", i), {56'd0, t}, {56'd0, 8'(8'h10 + i)});
    end

    // RX write sequence on channel 1.
    wr(4'd1, 4'h3, 32'h0000_0100);
    chk("rxlen1", {32'd0, rx_len[1]}, 64'h100);
    chk("no_start_on_len", 64'(rx_start), 64'd0);
    wr(4'd1, 4'h4, 32'h0000_0011);
    chk("rx_start_pulse", 64'(rx_start), 64'h2);
    chk("rx_off1", {33'd0, rx_off[1]}, 64'h8);
    chk("rx_last1", 64'(rx_last), 64'h2);
    chk("rxlen0_untouched", {32'd0, rx_len[0]}, 64'd0);
    tick();
    chk("rx_start_single", 64'(rx_start), 64'd0);
    // Writes to an out-of-range channel or a read-only offset are ignored.
    wr(4'd13, 4'h4, 32'h0000_0001);
    chk("oob_chnl_write", 64'(rx_start), 64'd0);
    wr(4'd1, 4'h8, 32'hFFFF_FFFF);
    chk("ro_off_write", {32'd0, rx_len[1]}, 64'h100);

    // SG TX sequence on channel 0.
    wr(4'd0, 4'h6, 32'hDEAD_0000);
    wr(4'd0, 4'h7, 32'h0000_0001);
    chk("no_sgtx_on_addr", 64'(sgtx_valid), 64'd0);
    wr(4'd0, 4'h5, 32'h0000_0040);
    chk("sgtx_pulse", 64'(sgtx_valid), 64'h1);
    chk("sgrx_quiet", 64'(sgrx_valid), 64'd0);
    chk("sg_addr0", sg_addr[0], 64'h1_DEAD_0000);
    chk("sg_len0", {32'd0, sg_len[0]}, 64'h40);
    tick();
    chk("sgtx_single", 64'(sgtx_valid), 64'd0);

    // Completion held under back-pressure.
    rd_issue(4'd2, 4'hD, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      chk("stall_cpl_valid", {63'd0, cpl_valid}, 64'd1);
      chk("stall_cpl_data", {32'd0, cpl_data}, 64'h1234);
      chk("stall_cpl_tag", {56'd0, cpl_tag}, 64'h5A);
      chk("stall_rd_ready", {63'd0, rd_ready}, 64'd0);
      tick();
    end
    rd_finish(d, t);
    chk("after_cpl_idle", {63'd0, cpl_valid}, 64'd0);
    chk("after_cpl_ready", {63'd0, rd_ready}, 64'd1);

    // Events 35 and 0 land in vector1 bit 3 and vector0 bit 0.
    evt[11][2] = 1'b1; evt[0][0] = 1'b1;
    tick();
    evt = '0;
    tick();
    chk("intr_set", {63'd0, intr_req}, 64'd1);
    rd_issue(4'd0, 4'hB, 8'h01); rd_finish(d, t);
    chk("vect0_read", {32'd0, d}, 64'h1);
    tick();
    chk("intr_held_by_v1", {63'd0, intr_req}, 64'd1);
    rd_issue(4'd0, 4'hB, 8'h02); rd_finish(d, t);
    chk("vect0_cleared", {32'd0, d}, 64'h0);
    rd_issue(4'd0, 4'hC, 8'h03); rd_finish(d, t);
    chk("vect1_read", {32'd0, d}, 64'h8);
    chk("intr_clear", {63'd0, intr_req}, 64'd0);

    // Event in the capture cycle of a vector0 read survives the clear.
    evt[1][1] = 1'b1;
    tick();
    evt = '0;
    evt[1][1] = 1'b1;
    rd_issue(4'd0, 4'hB, 8'h04);
    evt = '0;
    rd_finish(d, t);
    chk("sbc_returned", {32'd0, d}, 64'h10);
    rd_issue(4'd0, 4'hB, 8'h05); rd_finish(d, t);
    chk("sbc_still_set", {32'd0, d}, 64'h10);
    rd_issue(4'd0, 4'hB, 8'h06); rd_finish(d, t);
    chk("sbc_now_clear", {32'd0, d}, 64'h0);

    // Reset in the completion state drops the completion.
    rd_issue(4'd0, 4'hF, 8'h77);
    chk("pre_rst_cpl_valid", {63'd0, cpl_valid}, 64'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_cpl_valid", {63'd0, cpl_valid}, 64'd0);
    chk("midrst_rd_ready", {63'd0, rd_ready}, 64'd0);
    chk("midrst_rx_len1", {32'd0, rx_len[1]}, 64'd0);
    #3 reset_n = 1'b1;
    tick();
    chk("post_rst_rd_ready", {63'd0, rd_ready}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_no_cpl", {63'd0, cpl_valid}, 64'd0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
